bcd_convert_ctrl: RTL and testbench
===================================

Name: bcd_convert_ctrl

Overview:
Sequential binary-to-BCD converter controller. It sequences the per-digit "≥5 → add 3" correction datapath over WIDTH shift cycles (shift-add-3 / double-dabble). It produces DIGITS packed BCD digits for the decimal display path. Valid/ready handshakes on input and output let a producer (switch capture, counter) and a consumer (7-segment decoders) stall independently.

Parameters:
WIDTH, 8, bit width of the binary input value
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1 (checked at elaboration, fatal if violated)

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a value (high only in IDLE)
in_data  input  WIDTH  unsigned binary value
out_valid  output  1  out_bcd holds a completed conversion
out_ready  input  1  consumer accepts out_bcd this cycle
out_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
busy  output  1  high in SHIFT state

Behaviour:
- Reset (Resetn low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out_bcd=0, shift register=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid:
    - load shift reg = in_data
    - clear BCD accumulator
    - counter = WIDTH-1
    - go to SHIFT
  - SHIFT (busy=1, in_ready=0): every cycle, apply the correction to each accumulator digit, then shift {accumulator, shift reg} left by one.
    - Correction: digit ≥5 → digit+3, else unchanged.
    - The binary MSB enters accumulator bit 0.
    - If counter==0: go to DONE and register the result into out_bcd. Otherwise decrement counter.
  - DONE: out_valid=1, out_bcd stable. On out_ready go to IDLE; out_valid drops the next cycle.
- Latency: acceptance edge at cycle 0; out_valid high from cycle WIDTH+1. Throughput is one conversion per WIDTH+2 cycles when out_ready is held high.
- Width rules:
  - Corrected digits never exceed 4'd12 before the shift, so no carry leaves a digit.
  - Accumulator is 4*DIGITS bits; bits shifted past the top digit are discarded (unreachable given the parameter check).
- Boundaries:
  - in_valid while not IDLE is ignored; the producer must hold the value until in_ready.
  - in_data=0 → all-zero digits.
  - in_data=2^WIDTH-1 → correct maximum.
  - out_ready high in the same cycle DONE is entered has no effect until out_valid is visible; acceptance requires out_valid && out_ready.
  - Resetn low mid-SHIFT or in DONE aborts immediately; the partial result is never presented.
- out_bcd is updated only on the SHIFT→DONE transition; it holds its value in IDLE until the next completion.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: adds output blank_n [DIGITS-1:0], registered alongside out_bcd.
  - Bit i = 0 when digit i and all higher digits are zero, except digit 0, which is never blanked.
  - Example: value 7 with DIGITS=3 → blank_n=3'b001.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - constant BCD_DIGIT_W=4
  - constant ADD3_THRESHOLD=4'd5
  - function for the minimum digit count used by the elaboration check
- Sub-module: bcd_add3_digit (4-bit in, 4-bit out, combinational ≥5 → +3). Instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_data=8'd0 → out_valid at cycle 9, out_bcd=12'h000.
- in_data=8'd255 → out_bcd=12'h255. Then in_data=8'd9 → 12'h009. Then 8'd10 → 12'h010.
- out_ready held low 5 cycles after out_valid → out_bcd=12'h128 stable (input 128), in_ready=0 throughout. out_ready=1 → IDLE next cycle.
- in_valid pulsed during SHIFT with 8'd77 → ignored; the original 8'd200 conversion completes with 12'h200.
- Resetn low at SHIFT cycle 4 → all outputs immediately zero, in_ready=1. Then in_data=8'd99 → 12'h099.
- With LEADING_ZERO_BLANK_EN: 8'd7 → blank_n=3'b001; 8'd45 → 3'b011; 8'd0 → 3'b001.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter slice.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Smallest digit count d with 10^d > 2^width - 1.
    function automatic int min_digits(input int width);
        longint unsigned max_val;
        longint unsigned pw;
        int              d;
        max_val = (64'd1 << width) - 64'd1;
        pw      = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pw <= max_val) begin
                pw = pw * 64'd10;
                d  = d + 1;
            end
        end
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD digit correction step: values of five or more get three added before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESHOLD) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential shift-add-3 binary-to-BCD converter with valid/ready handshakes.
// Optional macro LEADING_ZERO_BLANK_EN adds a registered blank_n digit mask.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid to load a new value
// SHIFT | busy, one correct-and-shift step per cycle, WIDTH steps
// DONE  | out_valid high, out_bcd stable until out_ready
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
`ifdef LEADING_ZERO_BLANK_EN
    output logic [DIGITS-1:0]             blank_n,
`endif
    output logic                          busy
);

    localparam int AW = BCD_DIGIT_W * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    generate
        if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
            $fatal(1, "bcd_convert_ctrl: DIGITS too small to hold 2^WIDTH-1");
        end
    endgenerate

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_fix;
    logic [AW-1:0]    acc_nxt;
    logic [CW-1:0]    cnt;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3_digit u_add3 (
                .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (acc_fix[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Top accumulator bit falls off; the digit-count check makes that bit always zero.
    assign acc_nxt = {acc_fix[AW-2:0], shreg[WIDTH-1]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)   state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              lz_seen;

    always_comb begin
        lz_seen   = 1'b0;
        blank_nxt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (acc_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) begin
                lz_seen = 1'b1;
            end
            blank_nxt[i] = lz_seen || (i == 0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blank_n <= DIGITS'(1);
        end else if (state == SHIFT && cnt == '0) begin
            blank_n <= blank_nxt;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_bcd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    acc   <= acc_nxt;
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        out_bcd <= acc_nxt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Randomized self-checking bench for bcd_convert_ctrl against an arithmetic decimal model.
// Honours LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_bcd_convert_ctrl;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  busy;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]     blank_n;
`endif

    int passed = 0;
    int total  = 0;

    bcd_convert_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
`ifdef LEADING_ZERO_BLANK_EN
        .blank_n   (blank_n),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int pw;
        r  = '0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / pw) % 10);
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_blank(input int v);
        logic [DIGITS-1:0] b;
        int pw;
        b  = '0;
        pw = 1;
        for (int i = 0; i < DIGITS; i++) begin
            b[i] = (i == 0) || (v >= pw);
            pw = pw * 10;
        end
        return b;
    endfunction

    task automatic conv(input int v, input int hold, input bit pulse, input bit rdy_early);
        int cyc;
        bit hold_ok;
        logic [4*DIGITS-1:0] exp;
        exp = ref_bcd(v);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = WIDTH'(v);
        out_ready = rdy_early;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        chk("busy_shift", 32'(busy), 32'd1);
        chk("in_ready_shift", 32'(in_ready), 32'd0);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            if (pulse && cyc == 3) begin
                in_valid = 1'b1;
                in_data  = 8'd77;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(cyc), 32'(WIDTH + 1));
        chk("out_bcd", 32'(out_bcd), 32'(exp));
`ifdef LEADING_ZERO_BLANK_EN
        chk("blank_n", 32'(blank_n), 32'(ref_blank(v)));
`endif
        if (hold > 0) begin
            out_ready = 1'b0;
            hold_ok   = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                if (!out_valid || in_ready || busy || out_bcd !== exp) hold_ok = 1'b0;
            end
            chk("hold_stable", 32'(hold_ok), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("bcd_held_idle", 32'(out_bcd), 32'(exp));
    endtask

    initial begin
        int v;
        int hold;
        bit early;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        conv(0, 0, 1'b0, 1'b0);
        conv(255, 0, 1'b0, 1'b1);
        conv(9, 0, 1'b0, 1'b0);
        conv(10, 0, 1'b0, 1'b0);
        conv(128, 5, 1'b0, 1'b0);
        conv(200, 0, 1'b1, 1'b0);

        // Abort a conversion partway through SHIFT.
        in_valid = 1'b1;
        in_data  = 8'd150;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_bcd", 32'(out_bcd), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        chk("abort_no_result", 32'({out_valid, out_bcd}), 32'd0);
        conv(99, 0, 1'b0, 1'b0);

        conv(7, 0, 1'b0, 1'b0);
        conv(45, 1, 1'b0, 1'b0);
        conv(0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 25; n++) begin
            v     = int'($urandom_range(0, 255));
            early = 1'($urandom_range(0, 1));
            hold  = early ? 0 : int'($urandom_range(0, 3));
            conv(v, hold, 1'($urandom_range(0, 1)), early);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
